// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO write-domain control.
// Contents: default geometry (DEPTH, ADDR_W, PTR_W, DATA_W), the write-side
// FSM state type, and binary/gray pointer conversion helpers.
package afifo_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        StIdle,
        StClear
    } wr_state_e;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Write-side bus of the FIFO write controller.
// Carries the agent request (write_enable, wdata) into the controller and the
// storage-array write port (mem_we, mem_waddr, mem_wdata) out of it.
//   master : agent / storage side (drives the request, observes the write port)
//   slave  : fifo_write_ctrl
interface fifo_write_ctrl_if;
    import afifo_pkg::*;

    logic              write_enable;
    logic [DATA_W-1:0] wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output write_enable,
        output wdata,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  write_enable,
        input  wdata,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

endinterface

// File: rtl/afifo_sync_ff.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into this clock.
// Configuration macro: AFIFO_WR_SYNC3_EN selects 3 stages (default 2).
// Ports:
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset
//   i_clr   synchronous clear, active-high
//   i_d     asynchronous input bus
//   o_q     synchronised output (last stage)
module afifo_sync_ff #(
    parameter int unsigned Width = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

`ifdef AFIFO_WR_SYNC3_EN
    localparam int unsigned Stages = 3;
`else
    localparam int unsigned Stages = 2;
`endif

    logic [Width-1:0] r_stage [Stages];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Stages; i++) r_stage[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < Stages; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < Stages; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[Stages-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-domain control stage of the asynchronous FIFO.
// Accepts writes into the storage array, maintains the binary/gray write
// pointer, synchronises the read pointer into the write clock, produces all
// write-side status, and runs a DEPTH-cycle memory-zeroing sequence.
// Configuration macro: AFIFO_WR_SYNC3_EN (3-flop read-pointer synchroniser).
// Ports:
//   i_wclk              write clock
//   i_hw_rst_n          asynchronous active-low reset
//   i_sw_rst            synchronous soft reset (highest synchronous priority)
//   i_mem_rst           synchronous request to zero the storage array
//   i_afull_value       almost-full threshold (0 disables the flag)
//   i_rptr_gray_async   gray read pointer from the read clock domain
//   io_wr               write request in / storage write port out
//   o_wptr_gray         registered gray write pointer to the read domain
//   o_wfull             FIFO full
//   o_wr_almost_ful     occupancy >= threshold
//   o_overflow          one-cycle pulse per rejected request cycle
//   o_fifo_write_count  accepted writes, saturating at all-ones
//   o_wr_level          occupancy seen from the write domain, 0..DEPTH
module fifo_write_ctrl
    import afifo_pkg::*;
(
    input  logic              i_wclk,
    input  logic              i_hw_rst_n,
    input  logic              i_sw_rst,
    input  logic              i_mem_rst,
    input  logic [ADDR_W-1:0] i_afull_value,
    input  logic [PTR_W-1:0]  i_rptr_gray_async,
    fifo_write_ctrl_if.slave  io_wr,
    output logic [PTR_W-1:0]  o_wptr_gray,
    output logic              o_wfull,
    output logic              o_wr_almost_ful,
    output logic              o_overflow,
    output logic [PTR_W-1:0]  o_fifo_write_count,
    output logic [PTR_W-1:0]  o_wr_level
);

    wr_state_e         r_state, w_state_n;
    logic [PTR_W-1:0]  r_wbin, w_wbin_n;
    logic [PTR_W-1:0]  r_wptr_gray, w_gray_n;
    logic [PTR_W-1:0]  r_level, w_level_n;
    logic [PTR_W-1:0]  r_count, w_count_n;
    logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_n;
    logic              r_wfull, w_wfull_n;
    logic              r_almost, w_almost_n;
    logic              r_overflow, w_overflow_n;
    logic              w_acc;
    logic              w_full_match;
    logic [PTR_W-1:0]  w_rgray_s;
    logic [PTR_W-1:0]  w_rbin_s;

    afifo_sync_ff #(
        .Width (PTR_W)
    ) u_rptr_sync (
        .i_clk   (i_wclk),
        .i_rst_n (i_hw_rst_n),
        .i_clr   (i_sw_rst),
        .i_d     (i_rptr_gray_async),
        .o_q     (w_rgray_s)
    );

    assign w_rbin_s = gray2bin(w_rgray_s);

    always_comb begin
        w_state_n       = r_state;
        w_wbin_n        = r_wbin;
        w_count_n       = r_count;
        w_clr_addr_n    = r_clr_addr;
        w_overflow_n    = 1'b0;
        w_acc           = 1'b0;
        io_wr.mem_we    = 1'b0;
        io_wr.mem_waddr = r_wbin[ADDR_W-1:0];
        io_wr.mem_wdata = io_wr.wdata;

        unique case (r_state)
            StIdle: begin
                w_acc        = io_wr.write_enable & ~r_wfull & ~i_sw_rst & ~i_mem_rst;
                w_overflow_n = io_wr.write_enable & r_wfull;
                if (w_acc) begin
                    w_wbin_n = r_wbin + PTR_W'(1);
                    if (r_count != '1) w_count_n = r_count + PTR_W'(1);
                end
                if (i_mem_rst) begin
                    w_state_n    = StClear;
                    w_wbin_n     = '0;
                    w_count_n    = '0;
                    w_clr_addr_n = '0;
                end
                // Qualify with the async reset so no strobe leaks out while it is held.
                io_wr.mem_we = w_acc & i_hw_rst_n;
            end
            StClear: begin
                // Every request during the sweep is rejected.
                w_overflow_n    = io_wr.write_enable;
                io_wr.mem_we    = ~i_sw_rst & i_hw_rst_n;
                io_wr.mem_waddr = r_clr_addr;
                io_wr.mem_wdata = '0;
                w_clr_addr_n    = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_n = StIdle;
            end
            default: ;
        endcase

        w_gray_n     = bin2gray(w_wbin_n);
        w_level_n    = w_wbin_n - w_rbin_s;
        // Full when the pointers differ only in the two MSBs (gray wrap).
        w_full_match = (w_gray_n == {~w_rgray_s[PTR_W-1:PTR_W-2], w_rgray_s[PTR_W-3:0]});
        // Writes are blocked for the whole sweep by holding full.
        w_wfull_n    = (w_state_n == StClear) | w_full_match;
        w_almost_n   = (i_afull_value != '0) && (w_level_n >= {1'b0, i_afull_value});
    end

    always_ff @(posedge i_wclk or negedge i_hw_rst_n) begin
        if (!i_hw_rst_n) begin
            r_state     <= StIdle;
            r_wbin      <= '0;
            r_wptr_gray <= '0;
            r_level     <= '0;
            r_count     <= '0;
            r_clr_addr  <= '0;
            r_wfull     <= 1'b0;
            r_almost    <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (i_sw_rst) begin
            r_state     <= StIdle;
            r_wbin      <= '0;
            r_wptr_gray <= '0;
            r_level     <= '0;
            r_count     <= '0;
            r_clr_addr  <= '0;
            r_wfull     <= 1'b0;
            r_almost    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_wbin      <= w_wbin_n;
            r_wptr_gray <= w_gray_n;
            r_level     <= w_level_n;
            r_count     <= w_count_n;
            r_clr_addr  <= w_clr_addr_n;
            r_wfull     <= w_wfull_n;
            r_almost    <= w_almost_n;
            r_overflow  <= w_overflow_n;
        end
    end

    assign o_wptr_gray        = r_wptr_gray;
    assign o_wfull            = r_wfull;
    assign o_wr_almost_ful    = r_almost;
    assign o_overflow         = r_overflow;
    assign o_fifo_write_count = r_count;
    assign o_wr_level         = r_level;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl. Expected storage writes are queued as
// stimulus is driven and popped whenever the write strobe is observed.
module tb_fifo_write_ctrl;
    import afifo_pkg::*;

`ifdef AFIFO_WR_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sw_rst;
    logic              mem_rst;
    logic [ADDR_W-1:0] afull;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr_gray;
    logic              wfull;
    logic              almost;
    logic              overflow;
    logic [PTR_W-1:0]  wcount;
    logic [PTR_W-1:0]  level;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t              sb[$];
    logic [PTR_W-1:0] m_wbin;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    fifo_write_ctrl_if bus ();

    fifo_write_ctrl dut (
        .i_wclk             (clk),
        .i_hw_rst_n         (rst_n),
        .i_sw_rst           (sw_rst),
        .i_mem_rst          (mem_rst),
        .i_afull_value      (afull),
        .i_rptr_gray_async  (rptr),
        .io_wr              (bus),
        .o_wptr_gray        (wptr_gray),
        .o_wfull            (wfull),
        .o_wr_almost_ful    (almost),
        .o_overflow         (overflow),
        .o_fifo_write_count (wcount),
        .o_wr_level         (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples the write port before the edge, then returns 1 time unit after it.
    task automatic cycle();
        wr_t e;
        @(negedge clk);
        if (bus.mem_we !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_mem_we", 32'(bus.mem_we), 32'(0));
            end else begin
                e = sb.pop_front();
                check("mem_waddr", 32'(bus.mem_waddr), 32'(e.addr));
                check("mem_wdata", bus.mem_wdata, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic exp_acc);
        bus.write_enable = 1'b1;
        bus.wdata        = d;
        if (exp_acc) begin
            sb.push_back('{addr: m_wbin[ADDR_W-1:0], data: d});
            m_wbin++;
        end
        cycle();
        bus.write_enable = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wptr_gray"}, 32'(wptr_gray), 32'(0));
        check({tag, "_wfull"}, 32'(wfull), 32'(0));
        check({tag, "_almost"}, 32'(almost), 32'(0));
        check({tag, "_overflow"}, 32'(overflow), 32'(0));
        check({tag, "_count"}, 32'(wcount), 32'(0));
        check({tag, "_level"}, 32'(level), 32'(0));
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        rst_n = 1'b0; sw_rst = 1'b0; mem_rst = 1'b0; afull = '0; rptr = '0;
        bus.write_enable = 1'b0; bus.wdata = '0; m_wbin = '0;
        #12;
        check_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full with the read pointer parked at 0.
        for (int i = 0; i < 32; i++) begin
            wr(32'hA000_0000 + 32'(i), 1'b1);
            e = (i == 31);
            check("fill_level", 32'(level), 32'(i + 1));
            check("fill_full", 32'(wfull), 32'(e));
        end
        check("fill_count", 32'(wcount), 32'(32));
        check("fill_wptr_gray", 32'(wptr_gray), 32'h30);
        check("afull_zero_forced", 32'(almost), 32'(0));

        // Writes into a full FIFO are rejected and flagged.
        for (int i = 0; i < 2; i++) begin
            wr(32'h0BAD_0000 + 32'(i), 1'b0);
            check("ovf_pulse", 32'(overflow), 32'(1));
            check("ovf_level", 32'(level), 32'(32));
        end
        cycle();
        check("ovf_drop", 32'(overflow), 32'(0));

        // Read side catches up; release is delayed by the synchroniser.
        rptr = 6'b110000;
        repeat (LAT - 1) cycle();
        check("release_pessimistic", 32'(wfull), 32'(1));
        cycle();
        check("release_full", 32'(wfull), 32'(0));
        check("release_level", 32'(level), 32'(0));
        for (int i = 0; i < 32; i++) wr(32'hC000_0000 + 32'(i), 1'b1);
        check("sat_count", 32'(wcount), 32'(63));
        check("wrap_level", 32'(level), 32'(32));
        check("wrap_full", 32'(wfull), 32'(1));
        check("wrap_wptr_gray", 32'(wptr_gray), 32'(0));

        // Soft reset.
        rptr = '0; sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0; m_wbin = '0;
        check_zero("sw_rst");

        // Almost-full threshold and its release after a read.
        afull = 5'd28;
        for (int i = 0; i < 28; i++) begin
            wr(32'hD000_0000 + 32'(i), 1'b1);
            e = (i == 27);
            check("afull_rise", 32'(almost), 32'(e));
        end
        rptr = 6'b000001;
        for (int k = 1; k <= LAT; k++) begin
            cycle();
            e = (k < LAT);
            check("afull_fall", 32'(almost), 32'(e));
        end
        check("afull_level", 32'(level), 32'(27));

        // Memory clear from level 10.
        rptr = '0; sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0; m_wbin = '0;
        for (int i = 0; i < 10; i++) wr(32'hE000_0000 + 32'(i), 1'b1);
        check("pre_clear_level", 32'(level), 32'(10));
        for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: '0});
        mem_rst = 1'b1;
        cycle();
        mem_rst = 1'b0;
        check("clr_entry_full", 32'(wfull), 32'(1));
        check("clr_entry_level", 32'(level), 32'(0));
        check("clr_entry_count", 32'(wcount), 32'(0));
        check("clr_entry_gray", 32'(wptr_gray), 32'(0));
        for (int c = 0; c < 32; c++) begin
            if (c == 5) bus.write_enable = 1'b1;
            if (c == 10) mem_rst = 1'b1;
            cycle();
            bus.write_enable = 1'b0;
            mem_rst = 1'b0;
            if (c == 5) check("clr_overflow", 32'(overflow), 32'(1));
            if (c == 6) check("clr_overflow_drop", 32'(overflow), 32'(0));
            if (c == 15) check("clr_hold_full", 32'(wfull), 32'(1));
        end
        check("clr_all_written", 32'(sb.size()), 32'(0));
        check("clr_done_full", 32'(wfull), 32'(0));
        check("clr_done_level", 32'(level), 32'(0));
        cycle();
        m_wbin = '0;
        wr(32'h1234_5678, 1'b1);
        check("post_clr_level", 32'(level), 32'(1));

        // Soft reset with a write in the middle of a clear.
        for (int i = 0; i < 5; i++) sb.push_back('{addr: 5'(i), data: '0});
        mem_rst = 1'b1;
        cycle();
        mem_rst = 1'b0;
        repeat (5) cycle();
        sw_rst = 1'b1; bus.write_enable = 1'b1; bus.wdata = 32'hFFFF_FFFF;
        #1;
        check("swclr_mem_we", 32'(bus.mem_we), 32'(0));
        cycle();
        sw_rst = 1'b0; bus.write_enable = 1'b0; m_wbin = '0;
        check_zero("sw_mid_clear");
        check("swclr_sb_empty", 32'(sb.size()), 32'(0));
        cycle();

        // Asynchronous hard reset at level 17.
        for (int i = 0; i < 17; i++) wr(32'hF000_0000 + 32'(i), 1'b1);
        check("pre_hw_level", 32'(level), 32'(17));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("hw_rst");
        @(negedge clk); #1;
        rst_n = 1'b1; m_wbin = '0;
        @(posedge clk); #1;
        wr(32'h5555_AAAA, 1'b1);
        check("post_hw_level", 32'(level), 32'(1));
        check("post_hw_count", 32'(wcount), 32'(1));
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
